// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the RGB LED arbiter: FSM states, default sizing
// and the fixed-priority pick helper.
package led_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } led_state_e;

    localparam int DEFAULT_PWM_BITS    = 8;
    localparam int DEFAULT_HOLD_CYCLES = 12_000_000;
    localparam int DEFAULT_BLINK_BITS  = 24;
    localparam int MAX_REQ             = 32;

    // Isolates the lowest set bit (highest priority); x & -x in two's complement.
    function automatic logic [MAX_REQ-1:0] prio_pick(input logic [MAX_REQ-1:0] req_vec);
        return req_vec & (~req_vec + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED colour channel: duty latched at the PWM period boundary, compared
// against the shared counter, and registered onto the active-low pin.
module led_pwm_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wrap,
    input  logic                clear,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic                force_off,
    output logic                led_n
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_n_q, led_n_d;

    // Duty only moves on the wrap edge so a period is never cut short.
    always_comb begin
        duty_d  = duty_q;
        led_n_d = 1'b1;
        if (clear) begin
            duty_d = '0;
        end else if (wrap) begin
            duty_d = duty_in;
        end
        led_n_d = ~((pwm_cnt < duty_q) & ~force_off);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q  <= '0;
            led_n_q <= 1'b1;
        end else begin
            duty_q  <= duty_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one RGB LED between prioritised requesters with a minimum ownership
// time, then dims and optionally blinks the owner's colour.
module rgb_led_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int PWM_BITS    = DEFAULT_PWM_BITS,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int BLINK_BITS  = DEFAULT_BLINK_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*3*PWM_BITS-1:0] rgb_in,
    input  logic [NUM_REQ-1:0]            blink_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          led_r_n,
    output logic                          led_g_n,
    output logic                          led_b_n
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SLICE_W = 3 * PWM_BITS;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    led_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  busy_q;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

    logic [NUM_REQ-1:0]    higher_req;
    logic                  owner_req;
    logic [SLICE_W-1:0]    owner_rgb;
    logic                  owner_blink;
    logic                  blink_off;
    logic                  pwm_wrap;

    // grant - 1 on a one-hot vector masks every index above the owner's priority.
    assign owner_req  = |(req & grant_q);
    assign higher_req = req & (grant_q - NUM_REQ'(1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d    = NUM_REQ'(prio_pick(MAX_REQ'(req)));
                    hold_cnt_d = HOLD_RELOAD;
                    state_d    = OWNED;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if ((hold_cnt_q == '0) && (|higher_req)) begin
                    grant_d    = NUM_REQ'(prio_pick(MAX_REQ'(higher_req)));
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        pwm_wrap    = &pwm_cnt_q;
    end

    always_comb begin
        owner_rgb   = '0;
        owner_blink = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_rgb   = rgb_in[i*SLICE_W +: SLICE_W];
                owner_blink = blink_in[i];
            end
        end
    end

    assign blink_off = owner_blink & blink_cnt_q[BLINK_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            hold_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= |grant_d;
            hold_cnt_q  <= hold_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt   (pwm_cnt_q),
        .wrap      (pwm_wrap),
        .clear     (~busy_q),
        .duty_in   (owner_rgb[2*PWM_BITS +: PWM_BITS]),
        .force_off (blink_off),
        .led_n     (led_r_n)
    );

    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt   (pwm_cnt_q),
        .wrap      (pwm_wrap),
        .clear     (~busy_q),
        .duty_in   (owner_rgb[PWM_BITS +: PWM_BITS]),
        .force_off (blink_off),
        .led_n     (led_g_n)
    );

    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt   (pwm_cnt_q),
        .wrap      (pwm_wrap),
        .clear     (~busy_q),
        .duty_in   (owner_rgb[0 +: PWM_BITS]),
        .force_off (blink_off),
        .led_n     (led_b_n)
    );

endmodule
